fifo: RTL and testbench

FIFO -- requirements
Module: fifo

---
 rtl/fifo.sv | 87 ++++++++
 tb/tb_fifo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fifo.sv
// Circular-buffer FIFO with show-ahead head, synchronous flush, optional fall-through (FIFO_BYPASS_EN).
// Latency: a write is visible at deq one edge later; with FIFO_BYPASS_EN an empty FIFO passes enq to deq combinationally.
// Backpressure: enq_ready = !full; a dequeue in the same cycle never frees space for a write.
module fifo #(
    parameter int data_size   = 8,
    parameter int buffer_size = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [data_size-1:0] enq_data,
    input  logic                 enq_valid,
    output logic                 enq_ready,
    output logic [data_size-1:0] deq_data,
    output logic                 deq_valid,
    input  logic                 deq_ready,
    input  logic                 flush,
    output logic                 full,
    output logic                 empty
);

    localparam int cnt_w = $clog2(buffer_size + 1);
    localparam int ptr_w = (buffer_size > 1) ? $clog2(buffer_size) : 1;
    localparam logic [cnt_w-1:0] cnt_max  = cnt_w'(buffer_size);
    localparam logic [ptr_w-1:0] ptr_last = ptr_w'(buffer_size - 1);

    logic [data_size-1:0] mem [buffer_size];
    logic [ptr_w-1:0]     rd_ptr;
    logic [ptr_w-1:0]     wr_ptr;
    logic [cnt_w-1:0]     count;

    logic do_enq;
    logic do_deq;

    assign full      = (count == cnt_max);
    assign empty     = (count == '0);
    assign enq_ready = !full;

`ifdef FIFO_BYPASS_EN
    logic bypass;
    logic bypass_take;

    // Fall-through only while empty; a consumed bypass word never touches storage.
    assign bypass      = empty && !flush;
    assign bypass_take = bypass && enq_valid && deq_ready;
    assign deq_valid   = bypass ? enq_valid : !empty;
    assign deq_data    = bypass ? enq_data : mem[rd_ptr];
    assign do_enq      = enq_valid && enq_ready && !bypass_take;
`else
    assign deq_valid   = !empty;
    assign deq_data    = mem[rd_ptr];
    assign do_enq      = enq_valid && enq_ready;
`endif

    assign do_deq = deq_ready && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr <= (wr_ptr == ptr_last) ? '0 : wr_ptr + 1'b1;
            end
            if (do_deq) begin
                rd_ptr <= (rd_ptr == ptr_last) ? '0 : rd_ptr + 1'b1;
            end
            if (do_enq && !do_deq) begin
                count <= count + 1'b1;
            end else if (!do_enq && do_deq) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage is deliberately unreset; only pointers and count define contents.
    always_ff @(posedge clk) begin
        if (!flush && do_enq) begin
            mem[wr_ptr] <= enq_data;
        end
    end

endmodule

// File: tb/tb_fifo.sv
// Directed self-checking bench for fifo (data_size=10, buffer_size=5).
module tb_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] enq_data;
    logic       enq_valid;
    logic       enq_ready;
    logic [9:0] deq_data;
    logic       deq_valid;
    logic       deq_ready;
    logic       flush;
    logic       full;
    logic       empty;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    fifo #(.data_size(10), .buffer_size(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enq_data  (enq_data),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .deq_data  (deq_data),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .flush     (flush),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [9:0] q[$];

    initial begin
        rst_n = 1'b0; enq_data = '0; enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0;
        #2;
        check("rst_empty", 16'(empty), 16'h1);
        check("rst_full", 16'(full), 16'h0);
        check("rst_enq_ready", 16'(enq_ready), 16'h1);
        check("rst_deq_valid", 16'(deq_valid), 16'h0);
        #10 rst_n = 1'b1;
        step();

        // Single entry, one-cycle latency, then dequeued
        enq_valid = 1'b1; enq_data = 10'h001; deq_ready = 1'b1;
        #1;
        check("t1_no_ahead", 16'(deq_valid), 16'h0);
        step();
        enq_valid = 1'b0;
        check("t1_valid", 16'(deq_valid), 16'h1);
        check("t1_data", 16'(deq_data), 16'h001);
        step();
        check("t1_empty", 16'(empty), 16'h1);

        // deq_ready while empty is ignored
        step();
        check("t1_empty_deq", 16'(empty), 16'h1);

        // Three back-to-back writes then drain in order
        deq_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            enq_valid = 1'b1; enq_data = 10'(3 + i);
            step();
        end
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t2_valid", 16'(deq_valid), 16'h1);
            check("t2_data", 16'(deq_data), 16'(3 + i));
            step();
        end
        check("t2_empty", 16'(empty), 16'h1);

        // Fill to capacity, overflow write ignored, full+deq admits no write
        deq_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            enq_valid = 1'b1; enq_data = 10'h100 + 10'(i);
            step();
        end
        check("t3_full", 16'(full), 16'h1);
        check("t3_enq_ready", 16'(enq_ready), 16'h0);
        enq_data = 10'h3FF;
        step();
        check("t3_still_full", 16'(full), 16'h1);
        check("t3_head", 16'(deq_data), 16'h100);
        enq_data = 10'h3EE; deq_ready = 1'b1;
        step();
        enq_valid = 1'b0;
        check("t3_not_full", 16'(full), 16'h0);
        for (int i = 1; i < 5; i++) begin
            check("t3_drain", 16'(deq_data), 16'h100 + 16'(i));
            step();
        end
        check("t3_empty", 16'(empty), 16'h1);

        // Twelve write/read cycles across pointer wrap against a queue model
        q.delete();
        for (int i = 0; i < 12; i++) begin
            enq_valid = 1'b1; enq_data = 10'h200 + 10'(i);
            deq_ready = (i >= 2);
            #1;
            check("t4_valid", 16'(deq_valid), 16'(q.size() != 0));
            if (q.size() != 0) check("t4_data", 16'(deq_data), 16'(q[0]));
            check("t4_full", 16'(full), 16'(q.size() == 5));
            if (deq_ready && q.size() != 0) void'(q.pop_front());
            if (q.size() < 5) q.push_back(enq_data);
            step();
        end
        enq_valid = 1'b0; deq_ready = 1'b1;
        while (q.size() != 0) begin
            check("t4_drain", 16'(deq_data), 16'(q.pop_front()));
            step();
        end
        check("t4_empty", 16'(empty), 16'h1);

        // Flush wins over a same-cycle write
        deq_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            enq_valid = 1'b1; enq_data = 10'h050 + 10'(i);
            step();
        end
        flush = 1'b1; enq_data = 10'h155;
        step();
        flush = 1'b0; enq_valid = 1'b0;
        check("t5_empty", 16'(empty), 16'h1);
        check("t5_deq_valid", 16'(deq_valid), 16'h0);
        enq_valid = 1'b1; enq_data = 10'h0AA;
        step();
        enq_valid = 1'b0;
        check("t5_after_data", 16'(deq_data), 16'h0AA);
        deq_ready = 1'b1;
        step();
        check("t5_after_empty", 16'(empty), 16'h1);

        // Write into an empty FIFO with the consumer ready
        enq_valid = 1'b1; enq_data = 10'h2AA; deq_ready = 1'b1;
        #1;
`ifdef FIFO_BYPASS_EN
        check("t6_byp_valid", 16'(deq_valid), 16'h1);
        check("t6_byp_data", 16'(deq_data), 16'h2AA);
        step();
        enq_valid = 1'b0;
        check("t6_byp_empty", 16'(empty), 16'h1);
`else
        check("t6_nobyp_valid", 16'(deq_valid), 16'h0);
        step();
        enq_valid = 1'b0;
        check("t6_nobyp_valid2", 16'(deq_valid), 16'h1);
        check("t6_nobyp_data", 16'(deq_data), 16'h2AA);
        step();
        check("t6_nobyp_empty", 16'(empty), 16'h1);
`endif

        // Asynchronous reset mid-operation discards contents
        deq_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            enq_valid = 1'b1; enq_data = 10'h0F0 + 10'(i);
            step();
        end
        enq_valid = 1'b0;
        check("t7_pre_valid", 16'(deq_valid), 16'h1);
        #1 rst_n = 1'b0;
        #1;
        check("t7_rst_empty", 16'(empty), 16'h1);
        check("t7_rst_valid", 16'(deq_valid), 16'h0);
        step();
        rst_n = 1'b1;
        step();
        check("t7_post_empty", 16'(empty), 16'h1);
        enq_valid = 1'b1; enq_data = 10'h123;
        step();
        enq_valid = 1'b0;
        check("t7_resume", 16'(deq_data), 16'h123);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
